signal_demodulation: RTL and testbench
======================================

Name: signal_demodulation

Overview:
- Receive-side counterpart of the M-sequence modulator.
- Takes float32 samples in the modulator's output scaling (value = (DDS<<10 + MSEQ·K)/2^26) and converts them back to uint32 fixed point.
- Removes the locally supplied DDS reference and slices the residual into M-sequence chips.
- Acquires and tracks sync against a local LFSR, reporting lock state and chip error counts.

Parameters:
- LFSR_N, 7, M-sequence register length (2..16).
- POLY, 7'h60, feedback tap mask over the LFSR state; predicted chip = XOR of (state & POLY). Default is x^7+x^6+1.
- DDS_DELAY, 3, pipeline delay in cycles applied to DDS_ref before subtraction (0..15).
- VERIFY_LEN, 16, consecutive correct chips required to declare lock.
- WINDOW, 64, chip count of the error-monitoring window while locked.
- LOSS_THR, 8, errors within one window that force loss of lock.

Ports:
- MSEQ_clk, in, 1, clock.
- MSEQ_rst_n, in, 1, asynchronous active-low reset.
- Signal_Recv, in, 32, IEEE-754 single received sample.
- recv_valid, in, 1, Signal_Recv qualifier; one sample per asserted cycle.
- DDS_ref, in, 16, DDS sample matching the sample's modulation instant.
- para_T, in, 32, slicing threshold in uint32 units (software sets K·A/2); quasi-static.
- chip_out, out, 1, sliced chip.
- chip_valid, out, 1, chip_out qualifier.
- lock, out, 1, high in LOCK state.
- err_cnt, out, 16, chip errors since entering LOCK, saturating at 16'hFFFF.

Behaviour:
- Reset is asynchronous, active-low, on MSEQ_rst_n; clock is MSEQ_clk.
- All registers clear on reset: chip_out=0, chip_valid=0, lock=0, err_cnt=0, FSM=SEARCH, LFSR state=0, all counters=0, valid pipeline=0.
- Reset mid-operation discards in-flight samples.

Float to uint32 (stage 1, registered):
- Inputs: s=sign, e=exponent, m=mantissa; E=e-127+26.
- s=1, or e=0 (zero/denormal), or E<0 → 0.
- e=255 with m≠0 (NaN) → 0.
- e=255 with m=0 (Inf), or E>31 → 32'hFFFFFFFF.
- Otherwise floor({1,m}·2^(E-23)), truncating.

Subtract (stage 2):
- r = u − (DDS_ref delayed by DDS_DELAY, zero-extended, <<10).
- Computed 33-bit signed; negative clamps to 0.

Slice (stage 3):
- chip = (r ≥ para_T), unsigned compare.
- chip_valid pulses 3 cycles after recv_valid.
- Gaps in recv_valid propagate unchanged; no backpressure.

Sync FSM (advances only on chip_valid; pred = ^(S & POLY); S shifts left with the new bit at S[0]):
- SEARCH:
  - Shift received chip into S and count chips.
  - When count reaches LFSR_N: if S≠0 → VERIFY (count cleared); if S=0 → stay, count cleared.
- VERIFY:
  - Compare pred with chip; shift in the received chip.
  - Any mismatch → SEARCH (count cleared, S kept).
  - VERIFY_LEN consecutive matches → LOCK, err_cnt=0, window counters=0.
- LOCK:
  - Shift in pred (flywheel), not the received chip.
  - On mismatch, err_cnt += 1 (saturating) and window error counter += 1.
  - When window error counter reaches LOSS_THR → SEARCH, with lock falling on the next cycle; err_cnt holds its value until the next LOCK entry.
  - At the end of each WINDOW chips, both window counters clear. If the final chip of a window is the LOSS_THR-th error, loss takes priority.
- lock is registered and equals (state==LOCK).

Test Plan:
- Reset check: hold reset with recv_valid=1 → all outputs 0. Release → first chip_valid exactly 3 cycles after the first recv_valid.
- Conversion:
  - DDS_ref=0, para_T=32'h02000000.
  - Signal_Recv=32'h3F800000 (1.0) → chip 1; 32'h3F000000 (0.5) → chip 1 (equal to threshold); 32'h3E800000 (0.25) → chip 0.
  - 32'hBF800000 → chip 0; 32'h7F800000 → chip 1; 32'h7FC00000 → chip 0.
- DDS removal: DDS_ref=16'h8000 aligned per DDS_DELAY, sample=0.5+0.25 (32'h3F400000) → r=32'h01000000 → chip 0. The same sample with K-offset 1.5 (32'h3FC00000) → chip 1.
- Acquisition: clean 127-chip x^7+x^6+1 sequence → lock asserts after exactly 7+16 chips; err_cnt=0 over 1000 chips.
- Error tracking: once locked, invert 3 isolated chips → err_cnt=3 and lock held. Invert 8 chips within one 64-chip window → lock drops and the FSM returns to SEARCH.
- Degenerate and gap cases:
  - All-zero chip stream → never leaves SEARCH.
  - recv_valid toggling 1-0-1 → chip_valid pattern identical, delayed 3 cycles.
  - Assert reset while locked → lock=0 and err_cnt=0 immediately.

Source files
------------

// File: rtl/signal_demodulation.sv
// signal_demodulation: receive-side M-sequence demodulator.
//   Converts float32 samples to uint32 fixed point, removes the delayed DDS
//   reference, slices the residual into chips and tracks sync against a local
//   LFSR with SEARCH / VERIFY / LOCK states.
// Ports:
//   MSEQ_clk, MSEQ_rst_n   clock, asynchronous active-low reset
//   Signal_Recv, recv_valid float32 sample and its qualifier
//   DDS_ref                 DDS sample for the sample's modulation instant
//   para_T                  slicing threshold (uint32 units)
//   chip_out, chip_valid    sliced chip and qualifier (3 cycles after input)
//   lock                    high while in LOCK
//   err_cnt                 chip errors since LOCK entry, saturating
module signal_demodulation #(
  parameter int unsigned       LFSR_N     = 7,
  parameter logic [LFSR_N-1:0] POLY       = 7'h60,
  parameter int unsigned       DDS_DELAY  = 3,
  parameter int unsigned       VERIFY_LEN = 16,
  parameter int unsigned       WINDOW     = 64,
  parameter int unsigned       LOSS_THR   = 8
) (
  input  logic        MSEQ_clk,
  input  logic        MSEQ_rst_n,
  input  logic [31:0] Signal_Recv,
  input  logic        recv_valid,
  input  logic [15:0] DDS_ref,
  input  logic [31:0] para_T,
  output logic        chip_out,
  output logic        chip_valid,
  output logic        lock,
  output logic [15:0] err_cnt
);

  localparam int unsigned CNT_MAX = (LFSR_N > VERIFY_LEN) ? LFSR_N : VERIFY_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned WC_W    = $clog2(WINDOW + 1);
  localparam int unsigned WE_W    = $clog2(LOSS_THR + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  // ---------------------------------------------------------------- stage 1
  logic               f_sign;
  logic [7:0]         f_exp;
  logic [22:0]        f_man;
  logic signed [9:0]  exp_e;
  logic [4:0]         exp_u;
  logic [31:0]        mant32;
  logic [31:0]        conv_c;
  logic [31:0]        u_q;
  logic               v1_q;

  // Float32 to uint32 with a 2^26 scale, truncating; out-of-range saturates.
  always_comb begin
    f_sign = Signal_Recv[31];
    f_exp  = Signal_Recv[30:23];
    f_man  = Signal_Recv[22:0];
    exp_e  = $signed({2'b00, f_exp}) - 10'sd101;
    exp_u  = exp_e[4:0];
    mant32 = {8'h00, 1'b1, f_man};
    conv_c = '0;
    if (f_sign) begin
      conv_c = '0;
    end else if (f_exp == 8'hFF) begin
      conv_c = (f_man == 23'd0) ? 32'hFFFF_FFFF : 32'h0;
    end else if ((f_exp == 8'h00) || (exp_e < 10'sd0)) begin
      conv_c = '0;
    end else if (exp_e > 10'sd31) begin
      conv_c = 32'hFFFF_FFFF;
    end else if (exp_u >= 5'd23) begin
      conv_c = mant32 << (exp_u - 5'd23);
    end else begin
      conv_c = mant32 >> (5'd23 - exp_u);
    end
  end

  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      u_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= recv_valid;
      if (recv_valid) u_q <= conv_c;
    end
  end

  // ---------------------------------------------------------------- DDS delay
  logic [15:0] dds_d;

  if (DDS_DELAY == 0) begin : g_no_delay
    assign dds_d = DDS_ref;
  end else begin : g_delay
    logic [15:0] dds_pipe [DDS_DELAY];

    always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
      if (!MSEQ_rst_n) begin
        for (int i = 0; i < int'(DDS_DELAY); i++) dds_pipe[i] <= '0;
      end else begin
        dds_pipe[0] <= DDS_ref;
        for (int i = 1; i < int'(DDS_DELAY); i++) dds_pipe[i] <= dds_pipe[i-1];
      end
    end

    assign dds_d = dds_pipe[DDS_DELAY-1];
  end

  // ---------------------------------------------------------------- stage 2
  logic [32:0] diff_c;
  logic [31:0] r_q;
  logic        v2_q;

  // 33-bit difference; a set top bit means negative and clamps to zero.
  assign diff_c = {1'b0, u_q} - {7'b0, dds_d, 10'b0};

  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      r_q  <= '0;
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) r_q <= diff_c[32] ? 32'h0 : diff_c[31:0];
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic chip_c;

  assign chip_c = (r_q >= para_T);

  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      chip_out   <= 1'b0;
      chip_valid <= 1'b0;
    end else begin
      chip_valid <= v2_q;
      if (v2_q) chip_out <= chip_c;
    end
  end

  // ---------------------------------------------------------------- sync FSM
  state_t            state_q, state_d;
  logic [LFSR_N-1:0] s_q, s_d, s_shift;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WC_W-1:0]   win_chip_q, win_chip_d;
  logic [WE_W-1:0]   win_err_q, win_err_d;
  logic [15:0]       err_d;
  logic              lock_d;
  logic              pred, mis, loss;

  // The FSM consumes the chip in the same cycle it is registered on chip_out.
  assign s_shift = {s_q[LFSR_N-2:0], chip_c};
  assign pred    = ^(s_q & POLY);
  assign mis     = pred ^ chip_c;
  assign loss    = mis && (win_err_q == WE_W'(LOSS_THR - 1));

  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) state_q <= ST_SEARCH;
    else             state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    if (v2_q) begin
      case (state_q)
        ST_SEARCH: if ((cnt_q == CNT_W'(LFSR_N - 1)) && (s_shift != '0)) state_d = ST_VERIFY;
        ST_VERIFY: begin
          if (mis)                                       state_d = ST_SEARCH;
          else if (cnt_q == CNT_W'(VERIFY_LEN - 1))      state_d = ST_LOCK;
        end
        ST_LOCK:   if (loss) state_d = ST_SEARCH;
        default:   state_d = ST_SEARCH;
      endcase
    end
  end

  // Register / counter updates per state; LOCK flywheels on the prediction.
  always_comb begin
    s_d        = s_q;
    cnt_d      = cnt_q;
    win_chip_d = win_chip_q;
    win_err_d  = win_err_q;
    err_d      = err_cnt;
    if (v2_q) begin
      case (state_q)
        ST_SEARCH: begin
          s_d   = s_shift;
          cnt_d = (cnt_q == CNT_W'(LFSR_N - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
        ST_VERIFY: begin
          s_d = s_shift;
          if (mis) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(VERIFY_LEN - 1)) begin
            cnt_d      = '0;
            err_d      = '0;
            win_chip_d = '0;
            win_err_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_LOCK: begin
          s_d = {s_q[LFSR_N-2:0], pred};
          if (mis && (err_cnt != 16'hFFFF)) err_d = err_cnt + 16'd1;
          if (loss) begin
            cnt_d      = '0;
            win_chip_d = '0;
            win_err_d  = '0;
          end else if (win_chip_q == WC_W'(WINDOW - 1)) begin
            win_chip_d = '0;
            win_err_d  = '0;
          end else begin
            win_chip_d = win_chip_q + WC_W'(1);
            win_err_d  = win_err_q + WE_W'(mis);
          end
        end
        default: cnt_d = '0;
      endcase
    end
    lock_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      s_q        <= '0;
      cnt_q      <= '0;
      win_chip_q <= '0;
      win_err_q  <= '0;
      err_cnt    <= '0;
      lock       <= 1'b0;
    end else begin
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      win_chip_q <= win_chip_d;
      win_err_q  <= win_err_d;
      err_cnt    <= err_d;
      lock       <= lock_d;
    end
  end

endmodule

// File: tb/tb_signal_demodulation.sv
// Testbench for signal_demodulation: scoreboard of expected chips plus
// per-scenario checks of latency, conversion, DDS removal and sync tracking.
module tb_signal_demodulation;

  localparam logic [31:0] F_ONE  = 32'h3F80_0000;
  localparam logic [31:0] F_ZERO = 32'h0000_0000;
  localparam logic [31:0] T0     = 32'h0200_0000;

  logic        MSEQ_clk = 1'b0;
  logic        MSEQ_rst_n;
  logic [31:0] Signal_Recv;
  logic        recv_valid;
  logic [15:0] DDS_ref;
  logic [31:0] para_T;
  logic        chip_out;
  logic        chip_valid;
  logic        lock;
  logic [15:0] err_cnt;

  int   total = 0;
  int   bad   = 0;
  logic sb[$];
  logic lock_hist[$];
  logic mon_exp;
  logic [6:0] lfsr_st;

  always #5 MSEQ_clk = ~MSEQ_clk;

  signal_demodulation dut (
    .MSEQ_clk   (MSEQ_clk),
    .MSEQ_rst_n (MSEQ_rst_n),
    .Signal_Recv(Signal_Recv),
    .recv_valid (recv_valid),
    .DDS_ref    (DDS_ref),
    .para_T     (para_T),
    .chip_out   (chip_out),
    .chip_valid (chip_valid),
    .lock       (lock),
    .err_cnt    (err_cnt)
  );

  // Scoreboard: every produced chip is compared against the queued expectation.
  always @(negedge MSEQ_clk) begin
    if (MSEQ_rst_n === 1'b1 && chip_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL chip_unexpected: got chip_out=%0b with empty scoreboard", chip_out);
      end else begin
        mon_exp = sb.pop_front();
        if (chip_out !== mon_exp) begin
          bad++;
          $display("FAIL chip_value #%0d: got %0b expected %0b", lock_hist.size(), chip_out, mon_exp);
        end
      end
      lock_hist.push_back(lock);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic send(input logic [31:0] f, input logic e);
    @(posedge MSEQ_clk); #1;
    Signal_Recv = f;
    recv_valid  = 1'b1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge MSEQ_clk); #1;
      recv_valid = 1'b0;
    end
  endtask

  task automatic send_chip(input logic b);
    send(b ? F_ONE : F_ZERO, b);
  endtask

  task automatic gen_bit(output logic b);
    b = ^(lfsr_st & 7'h60);
    lfsr_st = {lfsr_st[5:0], b};
  endtask

  task automatic apply_reset();
    @(negedge MSEQ_clk);
    MSEQ_rst_n = 1'b0;
    recv_valid = 1'b0;
    sb.delete();
    repeat (2) @(negedge MSEQ_clk);
    MSEQ_rst_n = 1'b1;
    lock_hist.delete();
  endtask

  task automatic test_reset();
    MSEQ_rst_n  = 1'b0;
    recv_valid  = 1'b1;
    Signal_Recv = F_ONE;
    DDS_ref     = 16'h0;
    para_T      = T0;
    repeat (3) @(negedge MSEQ_clk);
    total++; if (chip_valid !== 1'b0) begin bad++; $display("FAIL reset_chip_valid: got %0b expected 0", chip_valid); end
    total++; if (chip_out !== 1'b0)   begin bad++; $display("FAIL reset_chip_out: got %0b expected 0", chip_out); end
    total++; if (lock !== 1'b0)       begin bad++; $display("FAIL reset_lock: got %0b expected 0", lock); end
    total++; if (err_cnt !== 16'h0)   begin bad++; $display("FAIL reset_err_cnt: got %0h expected 0", err_cnt); end
    recv_valid = 1'b0;
    @(negedge MSEQ_clk);
    MSEQ_rst_n = 1'b1;
    send(F_ONE, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge MSEQ_clk);
      total++;
      if (chip_valid !== (i == 3)) begin
        bad++;
        $display("FAIL first_latency cycle %0d: got chip_valid=%0b expected %0b", i, chip_valid, (i == 3));
      end
      @(posedge MSEQ_clk); #1;
      recv_valid = 1'b0;
    end
    idle(4);
  endtask

  task automatic test_conversion();
    apply_reset();
    DDS_ref = 16'h0;
    para_T  = T0;
    idle(6);
    send(32'h3F80_0000, 1'b1);  // 1.0
    send(32'h3F00_0000, 1'b1);  // 0.5, exactly the threshold
    send(32'h3E80_0000, 1'b0);  // 0.25
    send(32'hBF80_0000, 1'b0);  // negative
    send(32'h7F80_0000, 1'b1);  // +Inf saturates
    send(32'h7FC0_0000, 1'b0);  // NaN
    send(32'h4F80_0000, 1'b1);  // exponent above range saturates
    send(32'h0040_0000, 1'b0);  // denormal
    send(32'h3F00_0001, 1'b1);  // just above threshold
    send(32'h3EFF_FFFF, 1'b0);  // just below threshold
    idle(6);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL conversion_drain: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_dds_removal();
    DDS_ref = 16'h8000;
    para_T  = T0;
    idle(6);
    send(32'h3F40_0000, 1'b0);  // 0.75 - 0.5 = 0.25 below threshold
    send(32'h3FC0_0000, 1'b1);  // 1.5 - 0.5 = 1.0
    send(32'h3F80_0000, 1'b1);  // 1.0 - 0.5 equals threshold
    idle(6);
    para_T = 32'h8000_0000;
    send(32'h3E80_0000, 1'b0);  // negative residual clamps to 0
    send(32'h4F80_0000, 1'b1);  // saturated input stays large
    idle(6);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL dds_drain: got %0d pending expected 0", sb.size()); end
    DDS_ref = 16'h0;
    para_T  = T0;
  endtask

  task automatic test_acquisition();
    logic b;
    int   lock_lows;
    apply_reset();
    lfsr_st = 7'h01;
    for (int j = 0; j < 1000; j++) begin
      gen_bit(b);
      send_chip(b);
    end
    idle(6);
    total++;
    if (lock_hist.size() != 1000) begin bad++; $display("FAIL acq_count: got %0d chips expected 1000", lock_hist.size()); end
    if (lock_hist.size() == 1000) begin
      total++;
      if (lock_hist[21] !== 1'b0) begin bad++; $display("FAIL acq_early_lock: got lock=%0b at chip 22 expected 0", lock_hist[21]); end
      total++;
      if (lock_hist[22] !== 1'b1) begin bad++; $display("FAIL acq_lock_at_23: got lock=%0b expected 1", lock_hist[22]); end
      lock_lows = 0;
      for (int j = 22; j < 1000; j++) if (lock_hist[j] !== 1'b1) lock_lows++;
      total++;
      if (lock_lows != 0) begin bad++; $display("FAIL acq_lock_held: got %0d unlocked chips expected 0", lock_lows); end
    end
    total++;
    if (err_cnt !== 16'd0) begin bad++; $display("FAIL acq_err_cnt: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_error_tracking();
    logic b;
    logic inv;
    for (int j = 1000; j < 1500; j++) begin
      gen_bit(b);
      inv = (j == 1100) || (j == 1200) || (j == 1300);
      send_chip(b ^ inv);
    end
    idle(6);
    total++;
    if (err_cnt !== 16'd3) begin bad++; $display("FAIL err_isolated: got %0d expected 3", err_cnt); end
    total++;
    if (lock !== 1'b1) begin bad++; $display("FAIL err_lock_held: got %0b expected 1", lock); end
    for (int j = 1500; j < 1508; j++) begin
      gen_bit(b);
      send_chip(~b);
    end
    idle(6);
    total++;
    if (lock !== 1'b0) begin bad++; $display("FAIL err_loss: got lock=%0b expected 0", lock); end
    total++;
    if (err_cnt !== 16'd11) begin bad++; $display("FAIL err_hold_after_loss: got %0d expected 11", err_cnt); end
    if (lock_hist.size() == 1508) begin
      total++;
      if (lock_hist[1505] !== 1'b1) begin bad++; $display("FAIL err_early_loss: got lock=%0b after 6 errors expected 1", lock_hist[1505]); end
    end else begin
      total++; bad++;
      $display("FAIL err_count: got %0d chips expected 1508", lock_hist.size());
    end
  endtask

  task automatic test_all_zero();
    int highs;
    apply_reset();
    for (int j = 0; j < 200; j++) send_chip(1'b0);
    idle(6);
    highs = 0;
    foreach (lock_hist[j]) if (lock_hist[j] !== 1'b0) highs++;
    total++;
    if (highs != 0 || lock_hist.size() != 200) begin
      bad++;
      $display("FAIL zero_stream: got %0d locked of %0d chips expected 0 of 200", highs, lock_hist.size());
    end
    total++;
    if (lock !== 1'b0) begin bad++; $display("FAIL zero_stream_lock: got %0b expected 0", lock); end
  endtask

  task automatic test_gap();
    logic [7:0] pat;
    logic       e;
    pat = 8'b0100_1101;
    for (int i = 0; i < 11; i++) begin
      @(posedge MSEQ_clk); #1;
      Signal_Recv = F_ONE;
      if (i < 8) begin
        recv_valid = pat[i];
        if (pat[i]) sb.push_back(1'b1);
      end else begin
        recv_valid = 1'b0;
      end
      @(negedge MSEQ_clk);
      e = (i >= 3) ? pat[i-3] : 1'b0;
      total++;
      if (chip_valid !== e) begin
        bad++;
        $display("FAIL gap_pattern cycle %0d: got chip_valid=%0b expected %0b", i, chip_valid, e);
      end
    end
    idle(4);
  endtask

  task automatic test_reset_locked();
    logic b;
    apply_reset();
    lfsr_st = 7'h01;
    for (int j = 0; j < 46; j++) begin
      gen_bit(b);
      send_chip(b ^ (j == 40));
    end
    idle(6);
    total++;
    if (lock !== 1'b1 || err_cnt !== 16'd1) begin
      bad++;
      $display("FAIL pre_reset: got lock=%0b err_cnt=%0d expected 1/1", lock, err_cnt);
    end
    for (int j = 0; j < 3; j++) begin
      gen_bit(b);
      send_chip(b);
    end
    #2;
    MSEQ_rst_n = 1'b0;
    sb.delete();
    #1;
    total++;
    if (lock !== 1'b0 || err_cnt !== 16'd0 || chip_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_while_locked: got lock=%0b err_cnt=%0d chip_valid=%0b expected 0/0/0", lock, err_cnt, chip_valid);
    end
    @(negedge MSEQ_clk);
    recv_valid = 1'b0;
    MSEQ_rst_n = 1'b1;
    idle(6);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL reset_flush: got %0d pending expected 0", sb.size()); end
  endtask

  initial begin
    Signal_Recv = '0;
    recv_valid  = 1'b0;
    DDS_ref     = '0;
    para_T      = T0;
    MSEQ_rst_n  = 1'b0;
    test_reset();
    test_conversion();
    test_dds_removal();
    test_acquisition();
    test_error_tracking();
    test_all_zero();
    test_gap();
    test_reset_locked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
